// File: rtl/free_list.sv
// Circular FIFO of free physical register tags: offers up to N tags to dispatch
// each cycle and is refilled with up to N tags released by retirement.
`ifndef PHYS_REG_SZ_R10K
`define PHYS_REG_SZ_R10K 64
`endif
`ifndef N
`define N 3
`endif

module free_list #(
   parameter  int PHYS_REGS = `PHYS_REG_SZ_R10K,
   parameter  int ARCH_REGS = 32,
   parameter  int N         = `N,
   localparam int DEPTH     = PHYS_REGS - ARCH_REGS,
   localparam int IDX_W     = $clog2(PHYS_REGS),
   localparam int RN_W      = $clog2(N + 1),
   localparam int CNT_W     = $clog2(DEPTH + 1),
   localparam int PTR_W     = $clog2(DEPTH)
) (
   input  logic                        clock,
   input  logic                        reset,
   input  logic [RN_W-1:0]             rd_num,
   input  logic [N-1:0][IDX_W-1:0]     wr_reg,
   input  logic [RN_W-1:0]             wr_num,
   output logic [N-1:0][IDX_W-1:0]     rd_regs,
   output logic [CNT_W-1:0]            num_avail,
   output logic                        error,
   output logic [PTR_W-1:0]            debug_head,
   output logic [PTR_W-1:0]            debug_tail,
   output logic [DEPTH-1:0][IDX_W-1:0] debug_entries
);

   localparam logic [CNT_W:0] DEPTH_X = DEPTH[CNT_W:0];

   logic [DEPTH-1:0][IDX_W-1:0] entries_q, entries_d;
   logic [PTR_W-1:0]            head_q, head_d;
   logic [PTR_W-1:0]            tail_q, tail_d;
   logic [CNT_W-1:0]            count_q, count_d;
   logic                        error_q, error_d;
   logic [CNT_W:0]              cnt_ext;
   logic                        underflow;
   logic                        overflow;

   // Offsets never exceed DEPTH, so one conditional subtract is an exact mod
   // even when DEPTH is not a power of two.
   function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] base,
                                                 input logic [CNT_W-1:0] off);
      logic [CNT_W:0] sum;
      sum = (CNT_W+1)'(base) + (CNT_W+1)'(off);
      if (sum >= DEPTH_X) sum = sum - DEPTH_X;
      return sum[PTR_W-1:0];
   endfunction

   always_comb begin
      head_d    = wrap_add(head_q, CNT_W'(rd_num));
      tail_d    = wrap_add(tail_q, CNT_W'(wr_num));
      cnt_ext   = {1'b0, count_q} + (CNT_W+1)'(wr_num) - (CNT_W+1)'(rd_num);
      underflow = (CNT_W+1)'(rd_num) > {1'b0, count_q};
      overflow  = !underflow && (cnt_ext > DEPTH_X);
      count_d   = cnt_ext[CNT_W-1:0];
      error_d   = error_q | underflow | overflow;
      entries_d = entries_q;
      for (int j = 0; j < N; j++) begin
         if (RN_W'(j) < wr_num) entries_d[wrap_add(tail_q, CNT_W'(j))] = wr_reg[j];
      end
   end

   always_comb begin
      rd_regs = '0;
      for (int i = 0; i < N; i++) begin
         if (CNT_W'(i) < count_q) rd_regs[i] = entries_q[wrap_add(head_q, CNT_W'(i))];
      end
   end

   // NOTE: the tag storage is reset too, because the list starts full of the
   // unmapped tags; it is not free-running scratch memory.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) entries_q[i] <= IDX_W'(ARCH_REGS + i);
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= DEPTH[CNT_W-1:0];
         error_q <= 1'b0;
      end else begin
         entries_q <= entries_d;
         head_q    <= head_d;
         tail_q    <= tail_d;
         count_q   <= count_d;
         error_q   <= error_d;
      end
   end

   assign num_avail     = count_q;
   assign error         = error_q;
   assign debug_head    = head_q;
   assign debug_tail    = tail_q;
   assign debug_entries = entries_q;

endmodule

// File: tb/tb_free_list.sv
// Directed bench for free_list with PHYS_REGS=64, ARCH_REGS=32, N=3 (DEPTH=32).
module tb_free_list;

   localparam int PHYS_REGS = 64;
   localparam int ARCH_REGS = 32;
   localparam int N         = 3;
   localparam int DEPTH     = PHYS_REGS - ARCH_REGS;
   localparam int IDX_W     = $clog2(PHYS_REGS);
   localparam int RN_W      = $clog2(N + 1);
   localparam int CNT_W     = $clog2(DEPTH + 1);
   localparam int PTR_W     = $clog2(DEPTH);

   logic                        clock = 1'b0;
   logic                        reset = 1'b1;
   logic [RN_W-1:0]             rd_num = '0;
   logic [N-1:0][IDX_W-1:0]     wr_reg = '0;
   logic [RN_W-1:0]             wr_num = '0;
   logic [N-1:0][IDX_W-1:0]     rd_regs;
   logic [CNT_W-1:0]            num_avail;
   logic                        error;
   logic [PTR_W-1:0]            debug_head;
   logic [PTR_W-1:0]            debug_tail;
   logic [DEPTH-1:0][IDX_W-1:0] debug_entries;

   int n_cmp = 0;
   int n_bad = 0;

   free_list #(.PHYS_REGS(PHYS_REGS), .ARCH_REGS(ARCH_REGS), .N(N)) dut (
      .clock(clock), .reset(reset), .rd_num(rd_num), .wr_reg(wr_reg), .wr_num(wr_num),
      .rd_regs(rd_regs), .num_avail(num_avail), .error(error),
      .debug_head(debug_head), .debug_tail(debug_tail), .debug_entries(debug_entries)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input int got, input int exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic drive(input int rn, input int wn, input int w0, input int w1, input int w2);
      rd_num    = RN_W'(rn);
      wr_num    = RN_W'(wn);
      wr_reg[0] = IDX_W'(w0);
      wr_reg[1] = IDX_W'(w1);
      wr_reg[2] = IDX_W'(w2);
   endtask

   task automatic check_regs(input string tag, input int e0, input int e1, input int e2);
      check({tag, ".rd0"}, int'(rd_regs[0]), e0);
      check({tag, ".rd1"}, int'(rd_regs[1]), e1);
      check({tag, ".rd2"}, int'(rd_regs[2]), e2);
   endtask

   task automatic do_reset();
      @(negedge clock);
      reset = 1'b1;
      drive(0, 0, 0, 0, 0);
      @(negedge clock);
      reset = 1'b0;
   endtask

   initial begin
      #12 reset = 1'b0;
      #1;
      check("rst.avail", int'(num_avail), 32);
      check_regs("rst", 32, 33, 34);
      check("rst.error", int'(error), 0);

      // Drain: ten pops of 3, then a pop of 2 empties the list.
      drive(3, 0, 0, 0, 0);
      for (int k = 1; k <= 10; k++) begin
         tick();
         check($sformatf("drain%0d.avail", k), int'(num_avail), 32 - 3 * k);
         check($sformatf("drain%0d.rd0", k), int'(rd_regs[0]), 32 + 3 * k);
      end
      drive(2, 0, 0, 0, 0);
      tick();
      check("empty.avail", int'(num_avail), 0);
      check_regs("empty", 0, 0, 0);
      check("empty.error", int'(error), 0);

      // Refill from empty; pushed tags appear only on the following cycle.
      drive(0, 3, 5, 9, 17);
      tick();
      check("push3.avail", int'(num_avail), 3);
      check_regs("push3", 5, 9, 17);
      drive(0, 1, 20, 0, 0);
      tick();
      check("push1.avail", int'(num_avail), 4);
      check_regs("push1", 5, 9, 17);

      // Steady pop3/push3 walks head from 0 to 30 with count held at 4.
      for (int c = 0; c < 10; c++) begin
         drive(3, 3, 3 * c + 1, 3 * c + 2, 3 * c + 3);
         tick();
      end
      check("prewrap.head", int'(debug_head), 30);
      check("prewrap.avail", int'(num_avail), 4);
      check_regs("prewrap", 27, 28, 29);
      drive(3, 3, 50, 51, 52);
      tick();
      check("wrap.head", int'(debug_head), 1);
      check("wrap.tail", int'(debug_tail), 5);
      check("wrap.avail", int'(num_avail), 4);
      check_regs("wrap", 30, 50, 51);
      check("wrap.error", int'(error), 0);

      // Asynchronous reset away from any rising edge.
      drive(0, 0, 0, 0, 0);
      @(negedge clock);
      #1 reset = 1'b1;
      #1;
      check("arst.avail", int'(num_avail), 32);
      check_regs("arst", 32, 33, 34);
      check("arst.error", int'(error), 0);
      check("arst.head", int'(debug_head), 0);
      @(negedge clock);
      reset = 1'b0;

      // Full list with simultaneous pop and push.
      drive(3, 3, 40, 41, 42);
      tick();
      check("fullrw.avail", int'(num_avail), 32);
      check("fullrw.error", int'(error), 0);
      check_regs("fullrw", 35, 36, 37);
      tick();
      check("fullrw2.avail", int'(num_avail), 32);
      check("fullrw2.error", int'(error), 0);

      // Overflow: push into a full list without a pop.
      drive(0, 1, 7, 0, 0);
      tick();
      check("ovf.error", int'(error), 1);
      drive(0, 0, 0, 0, 0);
      tick();
      check("ovf.hold", int'(error), 1);

      // Underflow: pop two with a single tag held.
      do_reset();
      check("rst2.error", int'(error), 0);
      drive(3, 0, 0, 0, 0);
      for (int k = 0; k < 10; k++) tick();
      drive(1, 0, 0, 0, 0);
      tick();
      check("one.avail", int'(num_avail), 1);
      check_regs("one", 63, 0, 0);
      check("one.error", int'(error), 0);
      drive(2, 0, 0, 0, 0);
      tick();
      check("udf.error", int'(error), 1);
      drive(0, 0, 0, 0, 0);
      tick();
      check("udf.hold", int'(error), 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
